// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int BITS    = 8;  // data word width
    localparam int ADDR_W  = 3;  // 8-word memory
    localparam int NUM_REQ = 2;  // requesters

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle: two req/ack channels plus the busy flag.
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [BITS-1:0]   wdata0, wdata1;
    logic              ack0, ack1;
    logic [BITS-1:0]   rdata0, rdata1;
    logic              busy;

    // Requester side
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1, busy
    );

    // Arbiter side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata0, rdata1, busy
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick; the priority pointer lives in the caller.
module rr_pick2 (
    input  logic [1:0] eligible,
    input  logic       prio,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Single contender wins outright; a tie goes to the requester prio names.
    always_comb begin
        gnt_valid = |eligible;
        gnt_id    = (eligible == 2'b11) ? prio : eligible[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin access controller for the 8-entry data memory. One access is
// sequenced IDLE/RESP -> ACCESS -> RESP; ack and read data are registered
// together at the edge that ends RESP.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     bus,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BITS-1:0]   mem_datain,
    input  logic [BITS-1:0]   mem_dataout
);

    state_t               state;
    logic                 prio;
    logic                 gnt_id;
    logic                 we_q;
    logic [NUM_REQ-1:0]   eligible;
    logic                 pick_valid;
    logic                 pick_id;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [BITS-1:0]      sel_wdata;

    // A requester whose ack is visible, or which is being acked now, still
    // holds req; it must not be granted a second time for the same request.
    always_comb begin
        eligible = {bus.req1 & ~bus.ack1, bus.req0 & ~bus.ack0};
        if (state == RESP) eligible[gnt_id] = 1'b0;
    end

    rr_pick2 u_pick (
        .eligible (eligible),
        .prio     (prio),
        .gnt_valid(pick_valid),
        .gnt_id   (pick_id)
    );

    // Route the winning requester's command towards the latch registers.
    always_comb begin
        sel_we    = pick_id ? bus.we1    : bus.we0;
        sel_addr  = pick_id ? bus.addr1  : bus.addr0;
        sel_wdata = pick_id ? bus.wdata1 : bus.wdata0;
    end

    // Access sequencer with registered memory-port and requester outputs.
    // NOTE: all state here uses <= so every register samples pre-edge values
    // (e.g. RESP acks the old gnt_id while a new grant overwrites it).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            prio        <= 1'b0;
            gnt_id      <= 1'b0;
            we_q        <= 1'b0;
            mem_en      <= 1'b0;
            mem_address <= '0;
            mem_datain  <= '0;
            bus.busy    <= 1'b0;
            bus.ack0    <= 1'b0;
            bus.ack1    <= 1'b0;
            bus.rdata0  <= '0;
            bus.rdata1  <= '0;
        end else begin
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (state == RESP) begin
                        if (gnt_id) bus.ack1 <= 1'b1;
                        else        bus.ack0 <= 1'b1;
                        if (!we_q) begin
                            if (gnt_id) bus.rdata1 <= mem_dataout;
                            else        bus.rdata0 <= mem_dataout;
                        end
                    end
                    if (pick_valid) begin
                        state       <= ACCESS;
                        gnt_id      <= pick_id;
                        prio        <= ~pick_id;
                        we_q        <= sel_we;
                        mem_en      <= sel_we;
                        mem_address <= sel_addr;
                        mem_datain  <= sel_wdata;
                        bus.busy    <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                ACCESS: begin
                    // Memory acts at this edge; park the port on a read of word 0.
                    state       <= RESP;
                    mem_en      <= 1'b0;
                    mem_address <= '0;
                    mem_datain  <= '0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 8-word data memory.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic              clk;
    logic              reset;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_address;
    logic [BITS-1:0]   mem_datain;
    logic [BITS-1:0]   mem_dataout;
    logic [BITS-1:0]   mem [8];

    int n_checks;
    int n_fail;
    int cyc;
    int ack0_cnt;
    int ack1_cnt;
    int overlap_cnt;
    int log_id[$];
    int log_t[$];

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .mem_en     (mem_en),
        .mem_address(mem_address),
        .mem_datain (mem_datain),
        .mem_dataout(mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: write when en, otherwise registered read; cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
            mem_dataout <= '0;
        end else if (mem_en) begin
            mem[mem_address] <= mem_datain;
        end else begin
            mem_dataout <= mem[mem_address];
        end
    end

    always_ff @(posedge clk) cyc <= cyc + 1;

    // Ack monitors sampled mid-cycle.
    always_ff @(negedge clk) begin
        if (bus.ack0) ack0_cnt <= ack0_cnt + 1;
        if (bus.ack1) ack1_cnt <= ack1_cnt + 1;
        if (bus.ack0 && bus.ack1) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One complete request on channel k; returns latency in cycles, read data
    // and the cycle number at which ack was seen.
    task automatic access(input int k, input logic we, input logic [2:0] a,
                          input logic [7:0] d, output int lat,
                          output logic [7:0] rd, output int t);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        rd   = '0;
        t    = 0;
        @(negedge clk);
        if (k == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if ((k == 0) ? bus.ack0 : bus.ack1) begin
                seen = 1'b1;
                lat  = i;
                t    = cyc;
                rd   = (k == 0) ? bus.rdata0 : bus.rdata1;
            end
        end
        if (k == 0) bus.req0 = 1'b0;
        else        bus.req1 = 1'b0;
        if (!seen) check($sformatf("timeout_req%0d", k), 32'd0, 32'd1);
    endtask

    int               lat0, lat1, t0, t1, a1;
    logic [7:0]       rd0, rd1;

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        ack0_cnt = 0; ack1_cnt = 0; overlap_cnt = 0;
        reset = 1'b0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

        // Reset state, sampled while reset is still low after two edges.
        repeat (2) @(negedge clk);
        check("rst_ack0",  bus.ack0, 0);
        check("rst_ack1",  bus.ack1, 0);
        check("rst_rdata0", bus.rdata0, 0);
        check("rst_rdata1", bus.rdata1, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_address, 0);
        check("rst_mem_din", mem_datain, 0);
        check("rst_state", dut.state, IDLE);
        reset = 1'b1;

        // Every word reads back 0 after reset.
        for (int a = 0; a < 8; a++) begin
            access(0, 1'b0, a[2:0], 8'h00, lat0, rd0, t0);
            check($sformatf("zero_addr%0d", a), rd0, 8'h00);
        end

        // Write then read addr 3 on requester 0, each acked 3 cycles later.
        access(0, 1'b1, 3'd3, 8'hA5, lat0, rd0, t0);
        check("wr3_latency", lat0, 3);
        access(0, 1'b0, 3'd3, 8'h00, lat0, rd0, t0);
        check("rd3_latency", lat0, 3);
        check("rd3_data", rd0, 8'hA5);

        // Simultaneous requests after a fresh reset: requester 0 first.
        do_reset();
        access(0, 1'b1, 3'd1, 8'h11, lat0, rd0, t0);
        access(1, 1'b1, 3'd2, 8'h22, lat1, rd1, t1);
        fork
            access(0, 1'b0, 3'd1, 8'h00, lat0, rd0, t0);
            access(1, 1'b0, 3'd2, 8'h00, lat1, rd1, t1);
        join
        check("sim_lat0", lat0, 3);
        check("sim_gap", t1 - t0, 2);
        check("sim_rdata0", rd0, 8'h11);
        check("sim_rdata1", rd1, 8'h22);

        // Both requesters keep requesting: strict alternation, 2-cycle spacing.
        log_id.delete();
        log_t.delete();
        fork
            begin
                int l; int tt; logic [7:0] r;
                for (int n = 0; n < 3; n++) begin
                    access(0, 1'b0, 3'd1, 8'h00, l, r, tt);
                    check($sformatf("alt_rd0_%0d", n), r, 8'h11);
                    log_id.push_back(0); log_t.push_back(tt);
                end
            end
            begin
                int l; int tt; logic [7:0] r;
                for (int n = 0; n < 3; n++) begin
                    access(1, 1'b0, 3'd2, 8'h00, l, r, tt);
                    check($sformatf("alt_rd1_%0d", n), r, 8'h22);
                    log_id.push_back(1); log_t.push_back(tt);
                end
            end
        join
        check("alt_count", log_id.size(), 6);
        for (int i = 0; i < 6 && i < log_id.size(); i++) begin
            check($sformatf("alt_order%0d", i), log_id[i], i % 2);
            if (i > 0) check($sformatf("alt_gap%0d", i), log_t[i] - log_t[i-1], 2);
        end

        // Reset during ACCESS of a write: no ack, write lost.
        @(negedge clk);
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 3'd7; bus.wdata1 = 8'h3C;
        @(negedge clk);
        check("mid_busy", bus.busy, 1);
        check("mid_mem_en", mem_en, 1);
        check("mid_mem_addr", mem_address, 7);
        a1 = ack1_cnt;
        reset = 1'b0;
        @(negedge clk);
        bus.req1 = 1'b0;
        reset = 1'b1;
        check("mid_state", dut.state, IDLE);
        check("mid_busy_after", bus.busy, 0);
        repeat (4) @(negedge clk);
        check("mid_no_ack1", ack1_cnt - a1, 0);
        access(1, 1'b0, 3'd7, 8'h00, lat1, rd1, t1);
        check("mid_rd7", rd1, 8'h00);

        // Write by requester 1 immediately followed by read of it by requester 0.
        fork
            access(1, 1'b1, 3'd5, 8'h5A, lat1, rd1, t1);
            begin
                @(negedge clk);
                access(0, 1'b0, 3'd5, 8'h00, lat0, rd0, t0);
            end
        join
        check("wr_rd_gap", t0 - t1, 2);
        check("wr_rd_data", rd0, 8'h5A);

        check("never_both_ack", overlap_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
